// File: rtl/usb_rx_bit_timer.sv
// -----------------------------------------------------------------------------
// usb_rx_bit_timer
//
// Purpose:
//   Bit-period timer for the USB receive path. A falling edge on the line
//   (with enable high) starts a bit window. A free-running phase counter then
//   marks one sample point per bit period. At each sample point the block
//   either emits shift_enable for the downstream decoder or, if the line is in
//   SE0, emits eop and waits for the line to return to J (D+ high).
//
// Configuration:
//   USB_RX_TIMER_RESYNC_EN - when defined, any line edge while ACTIVE reloads
//                            the phase counter to 0 so sampling tracks the
//                            transmitter's clock. When undefined, edges seen
//                            while ACTIVE are ignored and the phase free-runs
//                            from the starting falling edge.
//
// Parameters:
//   CLKS_PER_BIT - system clocks per USB bit period (>= 4)
//   SAMPLE_POINT - phase value at which a bit is sampled (< CLKS_PER_BIT)
//
// Ports:
//   clk          in   system clock, rising-edge active
//   rst          in   synchronous active-high reset
//   enable       in   receive enable from the protocol controller
//   falling_edge in   one-cycle pulse from the line edge detector
//   rising_edge  in   one-cycle pulse from the line edge detector
//   d_plus_sync  in   synchronized D+ level
//   d_minus_sync in   synchronized D- level
//   shift_enable out  one-cycle pulse: decoder samples a bit this cycle
//   byte_done    out  one-cycle pulse with the 8th shift_enable of a byte
//   bit_count    out  index of the next bit to be sampled (0..7)
//   eop          out  one-cycle pulse: SE0 seen at a sample point
//   active       out  high while the FSM is in ACTIVE
//
// Handshake: none. All inputs are level/pulse samples taken on every rising
// clock edge; there is no back-pressure. The pulses shift_enable, byte_done
// and eop are valid only in the cycle they are high and are derived
// combinationally from registered state and the current line levels.
// -----------------------------------------------------------------------------
module usb_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       falling_edge,
    input  logic       rising_edge,
    input  logic       d_plus_sync,
    input  logic       d_minus_sync,
    output logic       shift_enable,
    output logic       byte_done,
    output logic [2:0] bit_count,
    output logic       eop,
    output logic       active
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PHASE_MAX = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_SMP = PW'(SAMPLE_POINT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        EOP_WAIT = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;
    logic          se0;
    logic          at_sample;

    assign se0        = !d_plus_sync && !d_minus_sync;
    assign phase_next = (phase == PHASE_MAX) ? '0 : phase + PW'(1);

    // A reset cycle never reports a sample, so a byte cut short by reset
    // cannot produce a trailing byte_done or eop.
    assign at_sample    = !rst && (state == ACTIVE) && (phase == PHASE_SMP);
    assign shift_enable = at_sample && !se0;
    assign eop          = at_sample && se0;
    assign byte_done    = shift_enable && (bit_count == 3'd7);
    assign active       = (state == ACTIVE);

`ifdef USB_RX_TIMER_RESYNC_EN
    logic line_edge;
    // Simultaneous rising and falling pulses collapse into one edge.
    assign line_edge = rising_edge || falling_edge;
`else
    // Edges are ignored once running; rising_edge has no role in this build.
    logic unused_rising_edge;
    assign unused_rising_edge = rising_edge;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            bit_count <= '0;
        end else if (!enable) begin
            // Disable wins over any edge or SE0 transition in the same cycle.
            state     <= IDLE;
            phase     <= '0;
            bit_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (falling_edge) begin
                        state     <= ACTIVE;
                        phase     <= '0;
                        bit_count <= '0;
                    end
                end
                ACTIVE: begin
                    if (eop) begin
                        // bit_count is held so the partial count is visible
                        // while waiting for the line to return to J.
                        state <= EOP_WAIT;
                        phase <= '0;
                    end else begin
                        if (shift_enable) begin
                            bit_count <= bit_count + 3'd1;
                        end
`ifdef USB_RX_TIMER_RESYNC_EN
                        // A sample coincident with an edge is still taken
                        // above; only the phase is realigned here.
                        phase <= line_edge ? '0 : phase_next;
`else
                        phase <= phase_next;
`endif
                    end
                end
                EOP_WAIT: begin
                    if (d_plus_sync) begin
                        state     <= IDLE;
                        phase     <= '0;
                        bit_count <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    phase     <= '0;
                    bit_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// -----------------------------------------------------------------------------
// tb_usb_rx_bit_timer
//
// Purpose:
//   Self-checking bench for usb_rx_bit_timer with default parameters.
//   A reference model tracks the receiver as a mode plus the cycle at which
//   the current bit period began and the number of bits sampled so far; the
//   phase is derived as (cycle - start) mod CLKS_PER_BIT. Every cycle the
//   outputs are compared with the model, and directed scenarios add explicit
//   timing checks on top.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_usb_rx_bit_timer;

    localparam int CPB = 8;
    localparam int SP  = 3;
`ifdef USB_RX_TIMER_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_WAIT   = 2;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       falling_edge;
    logic       rising_edge;
    logic       d_plus_sync;
    logic       d_minus_sync;
    logic       shift_enable;
    logic       byte_done;
    logic [2:0] bit_count;
    logic       eop;
    logic       active;

    always #5 clk = ~clk;

    usb_rx_bit_timer #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_POINT (SP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .falling_edge (falling_edge),
        .rising_edge  (rising_edge),
        .d_plus_sync  (d_plus_sync),
        .d_minus_sync (d_minus_sync),
        .shift_enable (shift_enable),
        .byte_done    (byte_done),
        .bit_count    (bit_count),
        .eop          (eop),
        .active       (active)
    );

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model state ----------------
    int m_mode   = M_IDLE;
    int m_start  = 0;   // cycle index at which phase was last 0
    int m_bits   = 0;   // bits sampled since the current start
    int cyc      = 0;
    bit m_valid  = 1'b0;
    bit bc_known = 1'b0;

    // Observed outputs of the last step, for directed checks.
    logic       o_shift;
    logic       o_bd;
    logic       o_eop;
    logic       o_active;
    logic [2:0] o_bc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock cycle: predict, compare at negedge, advance model at posedge.
    task automatic step();
        int ph;
        bit se0, at_sp, e_shift, e_eop, e_bd;
        ph      = (cyc - m_start) % CPB;
        se0     = (d_plus_sync == 1'b0) && (d_minus_sync == 1'b0);
        at_sp   = m_valid && !rst && (m_mode == M_ACTIVE) && (ph == SP);
        e_shift = at_sp && !se0;
        e_eop   = at_sp && se0;
        e_bd    = e_shift && ((m_bits % 8) == 7);
        @(negedge clk);
        o_shift  = shift_enable;
        o_bd     = byte_done;
        o_eop    = eop;
        o_active = active;
        o_bc     = bit_count;
        if (m_valid) begin
            check("shift_enable", 32'(shift_enable), 32'(e_shift));
            check("byte_done",    32'(byte_done),    32'(e_bd));
            check("eop",          32'(eop),          32'(e_eop));
            check("active",       32'(active),       32'(m_mode == M_ACTIVE));
            if (m_mode != M_IDLE || bc_known)
                check("bit_count", 32'(bit_count), 32'(m_bits % 8));
        end
        @(posedge clk);
        if (rst) begin
            m_valid  = 1'b1;
            m_mode   = M_IDLE;
            m_bits   = 0;
            bc_known = 1'b1;
        end else if (m_valid) begin
            if (!enable) begin
                m_mode   = M_IDLE;
                m_bits   = 0;
                bc_known = 1'b1;
            end else begin
                case (m_mode)
                    M_IDLE: if (falling_edge) begin
                        m_mode  = M_ACTIVE;
                        m_start = cyc + 1;
                        m_bits  = 0;
                    end
                    M_ACTIVE: begin
                        if (e_eop) m_mode = M_WAIT;
                        else begin
                            if (e_shift) m_bits++;
                            if (RESYNC && (falling_edge || rising_edge)) m_start = cyc + 1;
                        end
                    end
                    default: if (d_plus_sync) begin
                        m_mode   = M_IDLE;
                        bc_known = 1'b0;
                    end
                endcase
            end
        end
        cyc++;
        #1;
    endtask

    // ---------------- driver helpers ----------------
    task automatic drive(input bit en, input bit fe, input bit re, input bit dp, input bit dm);
        rst          = 1'b0;
        enable       = en;
        falling_edge = fe;
        rising_edge  = re;
        d_plus_sync  = dp;
        d_minus_sync = dm;
    endtask

    // Random J or K (never SE0).
    task automatic drive_data(input bit en, input bit fe, input bit re);
        bit dp;
        dp = 1'($urandom_range(0, 1));
        drive(en, fe, re, dp, !dp);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int first_k, last_k, n_sh, bd_k, nxt_k;
        @(posedge clk);
        #1;

        // Reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            rst          = 1'b1;
            enable       = 1'($urandom_range(0, 1));
            falling_edge = 1'($urandom_range(0, 1));
            rising_edge  = 1'($urandom_range(0, 1));
            d_plus_sync  = 1'($urandom_range(0, 1));
            d_minus_sync = 1'($urandom_range(0, 1));
            step();
        end
        check("rst_shift",  32'(o_shift),  32'd0);
        check("rst_active", 32'(o_active), 32'd0);
        check("rst_bc",     32'(o_bc),     32'd0);

        drive(1, 0, 0, 1, 0);
        repeat (3) step();

        // One full byte from a single falling edge.
        first_k = -1; last_k = -1; n_sh = 0; bd_k = -1;
        for (int k = 0; k <= 61; k++) begin
            drive_data(1, k == 0, 0);
            step();
            if (o_shift) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                n_sh++;
            end
            if (o_bd) bd_k = k;
            if (k == 1)  check("byte_active_k1", 32'(o_active), 32'd1);
            if (k == 61) check("byte_bc_end",    32'(o_bc),     32'd0);
        end
        check("byte_first_shift", first_k, 32'd4);
        check("byte_last_shift",  last_k,  32'd60);
        check("byte_n_shift",     n_sh,    32'd8);
        check("byte_done_at",     bd_k,    32'd60);
        drive(0, 0, 0, 1, 0);
        step();

        // Edge during a bit: resync moves the next sample earlier.
        nxt_k = -1;
        for (int k = 0; k <= 14; k++) begin
            drive_data(1, k == 0, k == 6);
            step();
            if (o_shift && k > 4 && nxt_k < 0) nxt_k = k;
        end
        check("resync_next_shift", nxt_k, RESYNC ? 32'd10 : 32'd12);
        drive(0, 0, 0, 1, 0);
        step();

        // SE0 at a sample point, wait for J, then restart.
        for (int k = 0; k <= 28; k++) begin
            if (k == 12)                drive(1, 0, 0, 0, 0);
            else if (k > 12 && k < 20)  drive(1, 0, 0, 0, 1'($urandom_range(0, 1)));
            else if (k == 20 || k == 21) drive(1, 0, 0, 1, 0);
            else                        drive_data(1, k == 0 || k == 22, 0);
            step();
            if (k == 12) begin
                check("se0_eop",   32'(o_eop),   32'd1);
                check("se0_shift", 32'(o_shift), 32'd0);
            end
            if (k == 13) check("se0_active_off", 32'(o_active), 32'd0);
            if (k == 21) check("se0_idle",       32'(o_active), 32'd0);
            if (k == 23) begin
                check("restart_active", 32'(o_active), 32'd1);
                check("restart_bc",     32'(o_bc),     32'd0);
            end
            if (k == 26) check("restart_shift", 32'(o_shift), 32'd1);
        end
        drive(0, 0, 0, 1, 0);
        step();

        // Disable after three shifts; edges while disabled do nothing.
        n_sh = 0;
        for (int k = 0; k <= 41; k++) begin
            if (k < 21) drive_data(1, k == 0, 0);
            else        drive_data(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
            if (k == 20) check("dis_bc_before", 32'(o_bc), 32'd2);
            if (k == 22) begin
                check("dis_bc_after", 32'(o_bc),     32'd0);
                check("dis_active",   32'(o_active), 32'd0);
            end
            if (k >= 22 && o_shift) n_sh++;
        end
        check("dis_no_shift", n_sh, 32'd0);

        // Reset coincident with a falling edge in IDLE.
        drive(1, 1, 0, 1, 0);
        rst = 1'b1;
        step();
        drive(1, 0, 0, 1, 0);
        step();
        check("rst_fe_active", 32'(o_active), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            enable       = ($urandom_range(0, 79) != 0);
            falling_edge = ($urandom_range(0, 9) == 0);
            rising_edge  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 14) == 0) begin
                d_plus_sync  = 1'b0;
                d_minus_sync = 1'b0;
            end else begin
                d_plus_sync  = 1'($urandom_range(0, 1));
                d_minus_sync = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
